// File: rtl/bram_stream_reader.sv
// bram_stream_reader: read-side client for the simple-dual-port block RAM.
// Issues a burst of reads (base_addr, count) and streams the words out in
// address order on a valid/ready interface, through a 2-entry buffer.
// Optional feature macro: SR_LAST_EN adds the out_last port.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; buffer empty
// RUN   | issuing reads and draining the buffer until the last handshake
// FIN   | one-cycle completion; done high, busy low
module bram_stream_reader #(
  parameter int DWIDTH  = 16,
  parameter int LOG_LEN = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [LOG_LEN-1:0] base_addr,
  input  logic [LOG_LEN:0]   count,
  output logic               busy,
  output logic               done,
  output logic               enb,
  output logic [LOG_LEN-1:0] addrb,
  input  logic [DWIDTH-1:0]  dob,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DWIDTH-1:0]  out_data
`ifdef SR_LAST_EN
  ,
  output logic               out_last
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  localparam logic [LOG_LEN:0]   CNT_ZERO = '0;
  localparam logic [LOG_LEN:0]   CNT_ONE  = 1;
  localparam logic [LOG_LEN-1:0] ADDR_ONE = 1;

  state_t             state;
  logic [LOG_LEN-1:0] cur_addr;
  logic [LOG_LEN-1:0] addr_hold;
  logic [LOG_LEN:0]   issue_left;
  logic [LOG_LEN:0]   pop_left;
  logic [1:0]         occ;
  logic [DWIDTH-1:0]  fifo [2];
  logic               wr_ptr;
  logic               rd_ptr;
  logic               push;
  logic               hs;

  // Read issue depends only on registers, so out_ready never reaches enb.
  // occ<2 at issue guarantees a free slot, since the word lands at the
  // same edge the read is issued on.
  assign enb       = (state == RUN) && (issue_left != CNT_ZERO) && (occ != 2'd2);
  assign addrb     = enb ? cur_addr : addr_hold;
  assign out_valid = (occ != 2'd0);
  assign out_data  = fifo[rd_ptr];
  assign hs        = out_valid && out_ready;

  // The RAM samples enb/addrb on the falling edge, so dob already holds the
  // word at the rising edge that completes the issue: the pending flag is
  // just the issue itself.
  assign push = enb;

`ifdef SR_LAST_EN
  assign out_last = out_valid && (pop_left == CNT_ONE);
`endif

  // Control FSM: burst counters, address generation, busy/done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      cur_addr   <= '0;
      issue_left <= '0;
      pop_left   <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            if (count != CNT_ZERO) begin
              state      <= RUN;
              busy       <= 1'b1;
              cur_addr   <= base_addr;
              issue_left <= count;
              pop_left   <= count;
            end else begin
              state <= FIN;
              done  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (enb) begin
            cur_addr   <= cur_addr + ADDR_ONE;
            issue_left <= issue_left - CNT_ONE;
          end
          if (hs) begin
            pop_left <= pop_left - CNT_ONE;
            if (pop_left == CNT_ONE) begin
              state <= FIN;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        FIN: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  // Remember the last issued address so addrb holds it while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_hold <= '0;
    end else if (enb) begin
      addr_hold <= cur_addr;
    end
  end

  // 2-entry FIFO absorbing RAM latency and consumer backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo[0] <= '0;
      fifo[1] <= '0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      occ     <= 2'd0;
    end else begin
      if (push) begin
        fifo[wr_ptr] <= dob;
        wr_ptr       <= ~wr_ptr;
      end
      if (hs) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, hs})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_stream_reader.sv
// Testbench for bram_stream_reader: RAM model, burst table, scoreboard.
module tb_bram_stream_reader;

  localparam int DW = 16;
  localparam int LL = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [LL-1:0] base_addr = '0;
  logic [LL:0]   count = '0;
  logic          busy, done, enb;
  logic [LL-1:0] addrb;
  logic [DW-1:0] dob = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
`ifdef SR_LAST_EN
  logic          out_last;
`endif

  bram_stream_reader #(.DWIDTH(DW), .LOG_LEN(LL)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .count(count), .busy(busy), .done(done), .enb(enb), .addrb(addrb),
    .dob(dob), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data)
`ifdef SR_LAST_EN
    , .out_last(out_last)
`endif
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [256];

  // RAM read port samples on the falling edge.
  always @(negedge clk) if (enb) dob <= mem[addrb];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  logic [DW-1:0] exp_q [$];
  logic [LL-1:0] addr_q [$];
  int            cyc_cnt = 0;
  int            occ_m = 0;
  int            rem_m = 0;
  int            hs_cnt = 0;
  int            done_cnt = 0;
  int            last_hs = 0;
  int            burst_len = 0;
  logic [DW-1:0] first_w, last_w, prev_data;
  bit            prev_stall = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Monitor: checks issued addresses, stream data, occupancy and completion.
  always @(negedge clk) begin
    if (!rst_n) begin
      occ_m = 0;
      rem_m = 0;
      prev_stall = 0;
    end else begin
      if (enb) begin
        chk("issue_while_full", (occ_m == 2) ? 1 : 0, 0);
        if (addr_q.size() == 0) chk("unexpected_issue", 1, 0);
        else chk("addrb", 32'(addrb), 32'(addr_q.pop_front()));
      end
      chk("out_valid_vs_occ", 32'(out_valid), (occ_m != 0) ? 1 : 0);
      if (prev_stall) begin
        chk("stall_valid", 32'(out_valid), 1);
        chk("stall_data", 32'(out_data), 32'(prev_data));
      end
`ifdef SR_LAST_EN
      chk("out_last", 32'(out_last), (out_valid && rem_m == 1) ? 1 : 0);
`endif
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_word", 1, 0);
        else chk("out_data", 32'(out_data), 32'(exp_q.pop_front()));
        if (hs_cnt == 0) first_w = out_data;
        last_w = out_data;
        hs_cnt++;
        rem_m--;
        last_hs = cyc_cnt;
      end
      if (done) begin
        done_cnt++;
        chk("busy_low_with_done", 32'(busy), 0);
        if (burst_len > 0) chk("done_after_last_hs", 32'(cyc_cnt), 32'(last_hs + 1));
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      occ_m = occ_m + (enb ? 1 : 0) - ((out_valid && out_ready) ? 1 : 0);
    end
  end

  function automatic logic rdy(input int mode, input int c);
    case (mode)
      0:       return 1'b1;
      1:       return (c % 3) == 0;
      2:       return 1'($urandom_range(0, 1));
      default: return c >= 6;
    endcase
  endfunction

  task automatic prime(input int b, input int n);
    for (int i = 0; i < n; i++) begin
      addr_q.push_back(8'((b + i) % 256));
      exp_q.push_back(mem[(b + i) % 256]);
    end
    hs_cnt = 0;
    done_cnt = 0;
    rem_m = n;
    burst_len = n;
  endtask

  task automatic run_burst(input int b, input int n, input int mode, input int restart,
                           input logic [DW-1:0] efirst, input logic [DW-1:0] elast);
    bit finished = 0;
    prime(b, n);
    @(posedge clk); #1;
    start = 1'b1; base_addr = 8'(b); count = 9'(n); out_ready = rdy(mode, 0);
    @(posedge clk); #1;
    start = 1'b0; base_addr = 8'($urandom); count = 9'($urandom_range(1, 256));
    @(negedge clk);
    if (n > 0) begin
      chk("first_enb", 32'(enb), 1);
      chk("first_addrb", 32'(addrb), 32'(b));
      chk("busy_after_start", 32'(busy), 1);
    end else begin
      chk("zero_done", 32'(done), 1);
      chk("zero_busy", 32'(busy), 0);
    end
    for (int c = 1; c < 3000; c++) begin
      @(posedge clk); #1;
      if (c == 1 && n > 0) chk("valid_latency", 32'(out_valid), 1);
      out_ready = rdy(mode, c);
      start = (c == restart);
      if (c == restart) begin base_addr = 8'd99; count = 9'd2; end
      if (done_cnt != 0) begin finished = 1; break; end
    end
    start = 1'b0;
    if (!finished) chk("timeout_no_done", 1, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("done_once", 32'(done_cnt), 1);
    chk("word_count", 32'(hs_cnt), 32'(n));
    chk("exp_q_empty", 32'(exp_q.size()), 0);
    chk("addr_q_empty", 32'(addr_q.size()), 0);
    chk("busy_idle", 32'(busy), 0);
    if (n > 0) begin
      chk("first_word", 32'(first_w), 32'(efirst));
      chk("last_word", 32'(last_w), 32'(elast));
    end
  endtask

  typedef struct {
    int            base;
    int            cnt;
    int            mode;
    int            restart;
    logic [DW-1:0] first;
    logic [DW-1:0] last;
  } vec_t;

  vec_t vecs [8];

  initial begin
    vecs[0] = '{4,   4,   0, 0, 16'h104, 16'h107};
    vecs[1] = '{4,   4,   1, 0, 16'h104, 16'h107};
    vecs[2] = '{254, 4,   0, 0, 16'h1FE, 16'h101};
    vecs[3] = '{0,   0,   0, 0, 16'h000, 16'h000};
    vecs[4] = '{7,   5,   3, 0, 16'h107, 16'h10B};
    vecs[5] = '{100, 20,  2, 0, 16'h164, 16'h177};
    vecs[6] = '{250, 256, 0, 0, 16'h1FA, 16'h1F9};
    vecs[7] = '{4,   4,   0, 2, 16'h104, 16'h107};
    for (int k = 0; k < 256; k++) mem[k] = 16'(k + 256);

    #2;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_enb", 32'(enb), 0);
    chk("rst_addrb", 32'(addrb), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", 32'(out_data), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int v = 0; v < 8; v++)
      run_burst(vecs[v].base, vecs[v].cnt, vecs[v].mode, vecs[v].restart,
                vecs[v].first, vecs[v].last);

    // Reset in the middle of a 6-word burst after 2 words.
    begin
      bit reached = 0;
      prime(20, 6);
      @(posedge clk); #1;
      start = 1'b1; base_addr = 8'd20; count = 9'd6; out_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int c = 0; c < 50; c++) begin
        @(negedge clk);
        if (hs_cnt == 2) begin reached = 1; break; end
      end
      if (!reached) chk("rst_test_timeout", 1, 0);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("midrst_busy", 32'(busy), 0);
      chk("midrst_done", 32'(done), 0);
      chk("midrst_enb", 32'(enb), 0);
      chk("midrst_addrb", 32'(addrb), 0);
      chk("midrst_valid", 32'(out_valid), 0);
      chk("midrst_data", 32'(out_data), 0);
      repeat (3) begin
        @(negedge clk);
        chk("midrst_no_done", 32'(done), 0);
      end
      chk("midrst_done_cnt", 32'(done_cnt), 0);
      exp_q.delete();
      addr_q.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
    end
    run_burst(30, 5, 1, 0, 16'h11E, 16'h122);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bram_stream_reader.md
# bram_stream_reader

Read-side client for the team's simple-dual-port block RAM. Given a base address and a word count, it drives the RAM's read port (enable, address) and captures the read data. It then presents the words in address order on a valid/ready stream toward the datapath, with a 2-entry buffer that absorbs the one-cycle RAM read latency and downstream backpressure. It runs at full throughput (1 word/cycle) while the consumer holds ready high.

## Interface
- DWIDTH, 16, data word width; must match the RAM instance.
- LOG_LEN, 8, RAM address width; RAM depth is 2^LOG_LEN.
- clk  in  1  single clock; all state on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request a burst; sampled only in IDLE.
- base_addr  in  LOG_LEN  first address of the burst; sampled with start.
- count  in  LOG_LEN+1  number of words, 0..2^LOG_LEN; sampled with start.
- busy  out  1  high from start accept until the last word handshakes.
- done  out  1  one-cycle pulse after the last word handshakes.
- enb  out  1  RAM read enable (to RAM enb).
- addrb  out  LOG_LEN  RAM read address (to RAM addrb).
- dob  in  DWIDTH  RAM read data (from RAM dob).
- out_valid  out  1  out_data holds a word.
- out_ready  in  1  consumer accepts the word.
- out_data  out  DWIDTH  streamed word.
- out_last  out  1  only with SR_LAST_EN: marks the final word of the burst.

## Operation
- Reset values: busy=0, done=0, enb=0, addrb=0, out_valid=0, out_data=0, out_last=0. State is IDLE. The buffer is empty and the counters are 0.
- FSM states: IDLE, RUN, FIN.
- IDLE -> RUN: on start=1 when count!=0. Latch cur_addr=base_addr, issue_left=count and pop_left=count. Set busy=1.
- IDLE -> FIN: on start=1 when count==0. No RAM access occurs.
- RUN -> FIN: when a handshake (out_valid & out_ready) occurs with pop_left==1.
- FIN -> IDLE: unconditional. done=1 for exactly this one cycle and busy=0.
- start is ignored outside IDLE. base_addr and count may change freely while busy.
- Read issue: enb = (state==RUN) & (issue_left!=0) & (occ<2). Here occ is the buffer occupancy register, 0..2.
- enb and addrb are combinational from registers only. There is no path from out_ready to enb.
- addrb = cur_addr while enb=1; otherwise addrb holds its last value.
- The RAM samples enb/addrb on the negative clock edge, so dob is valid at the next posedge.
- On each issue, cur_addr increments and issue_left decrements.
- cur_addr wraps modulo 2^LOG_LEN, so address 2^LOG_LEN-1 is followed by 0.
- A one-bit pending flag, set by an issue, captures dob into the buffer tail at the following posedge.
- Buffer: 2-entry FIFO. The head drives out_data; out_valid = (occ!=0).
- Simultaneous push and pop leave occ unchanged and keep order.
- out_data and out_last are stable while out_valid & !out_ready.
- pop_left decrements on each handshake.
- Reset asserted mid-burst: all state returns to the reset values immediately. No done pulse. The buffer contents are discarded.

## Timing
- Start accepted at edge E0 gives enb=1 with addrb=base_addr in the cycle after E0. The word is captured at E1, so out_valid=1 after E1 (1-cycle latency).
- With out_ready held at 1: one word per cycle and occ stays at 1. For count=N, the last handshake is at edge E0+N and done is high in the cycle after it.
- With out_ready held at 0: at most 2 words are read, then enb=0 until a pop frees space.
- busy falls in the same cycle that done rises.

## Configuration
- SR_LAST_EN defined: the out_last port exists and equals (pop_left==1) & out_valid, qualified by the head word.
- SR_LAST_EN undefined: the out_last port and its logic are absent. All other behaviour is identical.

## Test plan
- RAM preloaded addr k = k+0x100; start with base=4, count=4, out_ready=1 -> words 0x104..0x107 on 4 consecutive cycles starting 1 cycle after start. done pulses once and busy drops with it.
- Same burst with out_ready toggling 1,0,0,1,... -> no word lost or duplicated. enb never asserts while occ==2. out_data is stable while stalled.
- count=0 -> no enb pulse, no out_valid, done pulses in the cycle after start.
- LOG_LEN=8, base=254, count=4 -> addresses 254, 255, 0, 1 in order.
- rst_n low after 2 of 6 words -> outputs reach reset values immediately and there is no done. A new start after release runs correctly from scratch.
- start pulsed again while busy -> ignored, and the burst completes with the original count. With SR_LAST_EN, out_last=1 only on the 4th word of a count=4 burst.
